// File: rtl/timer_irq_ctrl_if.sv
// Signal bundle between the decade-timer interrupt controller and its host/timer side.
// The master drives enable, timer flag and acknowledge; the slave is the controller.
interface timer_irq_ctrl_if #(
    parameter int unsigned CNT_W = 8
);
    logic             en;
    logic             t_in;
    logic             irq_ack;
    logic             timer_clr;
    logic             irq;
    logic [CNT_W-1:0] event_cnt;
    logic             missed;

    modport master (
        output en, t_in, irq_ack,
        input  timer_clr, irq, event_cnt, missed
    );

    modport slave (
        input  en, t_in, irq_ack,
        output timer_clr, irq, event_cnt, missed
    );
endinterface

// File: rtl/timer_irq_ctrl.sv
// Turns each rising edge of the timer's sticky terminal flag into a counted interrupt event,
// holding the timer cleared between arms and optionally re-arming it for periodic operation.
module timer_irq_ctrl #(
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned CLR_CYCLES = 2,
    parameter bit          AUTO_REARM = 1'b1
) (
    input logic             clk_in,
    input logic             arst,
    timer_irq_ctrl_if.slave bus
);

    localparam int unsigned CLR_W    = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StClear = 2'd1;
    localparam logic [1:0] StArmed = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic             t_q;
    logic [CLR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic             timer_clr_q, timer_clr_d;
    logic             irq_q, irq_d;
    logic [CNT_W-1:0] event_cnt_q, event_cnt_d;
    logic             missed_q, missed_d;
    logic             rise;

    assign rise = bus.t_in & ~t_q;

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        irq_d       = irq_q & ~bus.irq_ack;
        event_cnt_d = event_cnt_q;
        missed_d    = missed_q;

        // Dropping enable wins over everything, including a same-cycle expiry.
        if (!bus.en) begin
            state_d     = StIdle;
            clr_cnt_d   = '0;
            irq_d       = 1'b0;
            event_cnt_d = '0;
            missed_d    = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d     = StClear;
                    clr_cnt_d   = '0;
                    irq_d       = 1'b0;
                    event_cnt_d = '0;
                    missed_d    = 1'b0;
                end
                StClear: begin
                    clr_cnt_d = clr_cnt_q + CLR_W'(1);
                    if (clr_cnt_q == CLR_LAST) begin
                        state_d = StArmed;
                    end
                end
                StArmed: begin
                    if (rise) begin
                        event_cnt_d = event_cnt_q + CNT_W'(1);
                        irq_d       = 1'b1;
                        // A same-cycle ack retires the old request, so nothing was lost.
                        missed_d    = missed_q | (irq_q & ~bus.irq_ack);
                        clr_cnt_d   = '0;
                        state_d     = AUTO_REARM ? StClear : StDone;
                    end
                end
                StDone: begin
                    state_d = StDone;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end

        timer_clr_d = (state_d == StIdle) || (state_d == StClear);
    end

    always_ff @(posedge clk_in or posedge arst) begin
        if (arst) begin
            state_q     <= StIdle;
            t_q         <= 1'b0;
            clr_cnt_q   <= '0;
            timer_clr_q <= 1'b1;
            irq_q       <= 1'b0;
            event_cnt_q <= '0;
            missed_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            t_q         <= bus.t_in;
            clr_cnt_q   <= clr_cnt_d;
            timer_clr_q <= timer_clr_d;
            irq_q       <= irq_d;
            event_cnt_q <= event_cnt_d;
            missed_q    <= missed_d;
        end
    end

    assign bus.timer_clr = timer_clr_q;
    assign bus.irq       = irq_q;
    assign bus.event_cnt = event_cnt_q;
    assign bus.missed    = missed_q;

endmodule
